// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result checker: format width derivation,
// result class encoding and IEEE-style field helpers usable at any width up to MAX_W.
package fpu_pkg;

  localparam int MAX_W = 128;

  typedef logic [MAX_W-1:0] fp_word_t;

  typedef enum logic [1:0] {
    CLS_MATCH    = 2'b00,
    CLS_ROUND    = 2'b01,
    CLS_MISMATCH = 2'b10,
    CLS_ORPHAN   = 2'b11
  } chk_class_t;

  function automatic int calc_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic fp_word_t field_mask(input int n);
    fp_word_t mask;
    mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // Magnitude: everything below the sign bit, zero-extended.
  function automatic fp_word_t mag(input fp_word_t v, input int exp_w, input int man_w);
    return v & field_mask(exp_w + man_w);
  endfunction

  function automatic logic is_nan(input fp_word_t v, input int exp_w, input int man_w);
    fp_word_t exp_f;
    fp_word_t man_f;
    exp_f = (v >> man_w) & field_mask(exp_w);
    man_f = v & field_mask(man_w);
    return (exp_f == field_mask(exp_w)) && (man_f != '0);
  endfunction

  function automatic logic is_zero(input fp_word_t v, input int exp_w, input int man_w);
    return mag(v, exp_w, man_w) == '0;
  endfunction

endpackage

// File: rtl/fpu_chk_fifo.sv
// DEPTH x W synchronous FIFO holding golden values; head is read combinationally
// so the top level can compare it against a result in the same cycle it pops.
module fpu_chk_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign level   = count_reg;

  // Storage carries no reset; clear only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/fpu_result_checker.sv
// In-order scoreboard for an FPU result stream: classifies each result against the
// queued golden value as Match / Rounding / Mismatch and captures the first failure.
module fpu_result_checker
  import fpu_pkg::*;
#(
  parameter  int EXP_W   = 8,
  parameter  int MAN_W   = 23,
  parameter  int DEPTH   = 8,
  parameter  int ULP_TOL = 1,
  parameter  int CNT_W   = 16,
  localparam int W       = calc_w(EXP_W, MAN_W),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Clear,
  input  logic             ExpValid,
  input  logic [W-1:0]     ExpData,
  output logic             ExpReady,
  input  logic             ResValid,
  input  logic [W-1:0]     ResData,
  output logic [CNT_W-1:0] MatchCount,
  output logic [CNT_W-1:0] RoundCount,
  output logic [CNT_W-1:0] MismatchCount,
  output logic [CNT_W-1:0] OrphanCount,
  output logic [LW-1:0]    Level,
  output logic             FailSeen,
  output logic [CNT_W-1:0] FirstFailIdx,
  output logic [W-1:0]     FirstFailExp,
  output logic [W-1:0]     FirstFailRes
);

  logic         srst;
  logic [W-1:0] head;
  logic         full;
  logic         empty;
  logic         pop;

  logic [CNT_W-1:0] result_idx_reg;

  fp_word_t   e_ext;
  fp_word_t   r_ext;
  fp_word_t   e_mag;
  fp_word_t   r_mag;
  fp_word_t   mag_diff;
  logic       e_nan;
  logic       r_nan;
  chk_class_t cls;

  assign srst     = RST || Clear;
  assign pop      = ResValid && !empty;
  assign ExpReady = !full;

  fpu_chk_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .clear     (srst),
    .push      (ExpValid),
    .pop       (pop),
    .push_data (ExpData),
    .head      (head),
    .level     (Level),
    .full      (full),
    .empty     (empty)
  );

  assign e_ext    = fp_word_t'(head);
  assign r_ext    = fp_word_t'(ResData);
  assign e_mag    = mag(e_ext, EXP_W, MAN_W);
  assign r_mag    = mag(r_ext, EXP_W, MAN_W);
  assign e_nan    = is_nan(e_ext, EXP_W, MAN_W);
  assign r_nan    = is_nan(r_ext, EXP_W, MAN_W);
  assign mag_diff = (e_mag >= r_mag) ? (e_mag - r_mag) : (r_mag - e_mag);

  always_comb begin
    cls = CLS_MISMATCH;
    if (empty) begin
      cls = CLS_ORPHAN;
    end else if (e_nan && r_nan) begin
      cls = CLS_MATCH;
    end else if (head == ResData) begin
      cls = CLS_MATCH;
    end else if (is_zero(e_ext, EXP_W, MAN_W) && is_zero(r_ext, EXP_W, MAN_W)
                 && (head[W-1] != ResData[W-1])) begin
      cls = CLS_ROUND;
    end else if ((head[W-1] == ResData[W-1]) && !e_nan && !r_nan
                 && (mag_diff <= fp_word_t'(ULP_TOL))) begin
      // Magnitude adjacency also spans largest-finite to infinity.
      cls = CLS_ROUND;
    end
  end

  always_ff @(posedge CLK) begin
    if (srst) begin
      MatchCount     <= '0;
      RoundCount     <= '0;
      MismatchCount  <= '0;
      OrphanCount    <= '0;
      result_idx_reg <= '0;
      FailSeen       <= 1'b0;
      FirstFailIdx   <= '0;
      FirstFailExp   <= '0;
      FirstFailRes   <= '0;
    end else if (ResValid) begin
      if (result_idx_reg != '1) result_idx_reg <= result_idx_reg + 1'b1;
      case (cls)
        CLS_MATCH:    if (MatchCount != '1)    MatchCount    <= MatchCount + 1'b1;
        CLS_ROUND:    if (RoundCount != '1)    RoundCount    <= RoundCount + 1'b1;
        CLS_MISMATCH: if (MismatchCount != '1) MismatchCount <= MismatchCount + 1'b1;
        default:      if (OrphanCount != '1)   OrphanCount   <= OrphanCount + 1'b1;
      endcase
      if (!FailSeen && (cls == CLS_ROUND || cls == CLS_MISMATCH)) begin
        FailSeen     <= 1'b1;
        FirstFailIdx <= result_idx_reg;
        FirstFailExp <= head;
        FirstFailRes <= ResData;
      end
    end
  end

endmodule

// File: tb/tb_fpu_result_checker.sv
// Self-checking bench: classification vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference scoreboard.
module tb_fpu_result_checker;

  logic        CLK;
  logic        RST;
  logic        Clear;
  logic        ExpValid;
  logic [31:0] ExpData;
  logic        ExpReady;
  logic        ResValid;
  logic [31:0] ResData;
  logic [15:0] MatchCount;
  logic [15:0] RoundCount;
  logic [15:0] MismatchCount;
  logic [15:0] OrphanCount;
  logic [3:0]  Level;
  logic        FailSeen;
  logic [15:0] FirstFailIdx;
  logic [31:0] FirstFailExp;
  logic [31:0] FirstFailRes;

  fpu_result_checker dut (
    .CLK           (CLK),
    .RST           (RST),
    .Clear         (Clear),
    .ExpValid      (ExpValid),
    .ExpData       (ExpData),
    .ExpReady      (ExpReady),
    .ResValid      (ResValid),
    .ResData       (ResData),
    .MatchCount    (MatchCount),
    .RoundCount    (RoundCount),
    .MismatchCount (MismatchCount),
    .OrphanCount   (OrphanCount),
    .Level         (Level),
    .FailSeen      (FailSeen),
    .FirstFailIdx  (FirstFailIdx),
    .FirstFailExp  (FirstFailExp),
    .FirstFailRes  (FirstFailRes)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference scoreboard state
  logic [31:0] m_q[$];
  int          m_cnt[4];
  int          m_idx;
  bit          m_fail_seen;
  int          m_ff_idx;
  logic [31:0] m_ff_exp;
  logic [31:0] m_ff_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0 Match, 1 Rounding, 2 Mismatch; magnitudes treated as plain integers.
  function automatic int ref_class(input logic [31:0] e, input logic [31:0] r);
    bit     en;
    bit     rn;
    longint d;
    en = (e[30:23] == 8'hFF) && (e[22:0] != 0);
    rn = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    if (en && rn) return 0;
    if (e == r) return 0;
    if (e[30:0] == 0 && r[30:0] == 0) return 1;
    if (e[31] == r[31] && !en && !rn) begin
      d = longint'(e[30:0]) - longint'(r[30:0]);
      if (d < 0) d = -d;
      if (d <= 1) return 1;
    end
    return 2;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_idx = 0;
    m_fail_seen = 0;
    m_ff_idx = 0;
    m_ff_exp = 0;
    m_ff_res = 0;
  endtask

  task automatic model_step(input bit ev, input logic [31:0] ed, input bit rv,
                            input logic [31:0] rd, input bit rst);
    bit          ready;
    int          c;
    logic [31:0] g;
    if (rst) begin
      model_reset();
      return;
    end
    ready = (m_q.size() != 8);
    if (rv) begin
      if (m_q.size() == 0) begin
        c = 3;
      end else begin
        g = m_q.pop_front();
        c = ref_class(g, rd);
        if (c != 0 && !m_fail_seen) begin
          m_fail_seen = 1;
          m_ff_idx = m_idx;
          m_ff_exp = g;
          m_ff_res = rd;
        end
      end
      if (m_cnt[c] < 65535) m_cnt[c]++;
      if (m_idx < 65535) m_idx++;
    end
    if (ev && ready) m_q.push_back(ed);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".match"},    64'(MatchCount),    64'(m_cnt[0]));
    check({tag, ".round"},    64'(RoundCount),    64'(m_cnt[1]));
    check({tag, ".mismatch"}, 64'(MismatchCount), 64'(m_cnt[2]));
    check({tag, ".orphan"},   64'(OrphanCount),   64'(m_cnt[3]));
    check({tag, ".level"},    64'(Level),         64'(m_q.size()));
    check({tag, ".ready"},    64'(ExpReady),      64'(m_q.size() != 8));
    check({tag, ".failseen"}, 64'(FailSeen),      64'(m_fail_seen));
    check({tag, ".ffidx"},    64'(FirstFailIdx),  64'(m_ff_idx));
    check({tag, ".ffexp"},    64'(FirstFailExp),  64'(m_ff_exp));
    check({tag, ".ffres"},    64'(FirstFailRes),  64'(m_ff_res));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit ev, input logic [31:0] ed, input bit rv, input logic [31:0] rd,
                     input bit rst, input bit clr, input string tag);
    RST = rst; Clear = clr;
    ExpValid = ev; ExpData = ed;
    ResValid = rv; ResData = rd;
    model_step(ev, ed, rv, rd, rst || clr);
    @(posedge CLK);
    #1;
    RST = 0; Clear = 0; ExpValid = 0; ResValid = 0;
    check_all(tag);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 1, 0, "reset");
  endtask

  typedef struct {
    logic [31:0] exp_v;
    logic [31:0] res_v;
    int          cls;
  } vec_t;

  vec_t vecs[14];

  logic [31:0] specials[8];

  initial begin
    logic [31:0] ed;
    logic [31:0] rd;
    int          mode;

    RST = 0; Clear = 0; ExpValid = 0; ExpData = 0; ResValid = 0; ResData = 0;
    model_reset();

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 0};
    vecs[1]  = '{32'h3F800000, 32'h3F800001, 1};
    vecs[2]  = '{32'h3F800000, 32'hBF800000, 2};
    vecs[3]  = '{32'h40800000, 32'h00000000, 2};
    vecs[4]  = '{32'h7FC00000, 32'hFFC00001, 0};
    vecs[5]  = '{32'h00000000, 32'h80000000, 1};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F800000, 1};
    vecs[7]  = '{32'h3F800001, 32'h3F800000, 1};
    vecs[8]  = '{32'h3F800000, 32'h3F800002, 2};
    vecs[9]  = '{32'h7F800000, 32'h7F800000, 0};
    vecs[10] = '{32'h7F800000, 32'hFF800000, 2};
    vecs[11] = '{32'h7FC00000, 32'h7F800000, 2};
    vecs[12] = '{32'h00000001, 32'h00000000, 1};
    vecs[13] = '{32'h00000001, 32'h80000000, 2};

    specials[0] = 32'h00000000; specials[1] = 32'h80000000;
    specials[2] = 32'h7F800000; specials[3] = 32'h7F7FFFFF;
    specials[4] = 32'h7FC00000; specials[5] = 32'hFFC00001;
    specials[6] = 32'h3F800000; specials[7] = 32'h00000001;

    // Out of reset
    do_reset();
    check("reset.ready", 64'(ExpReady), 64'd1);
    check("reset.level", 64'(Level), 64'd0);

    // Classification table: one golden, one result, exactly one counter moves
    foreach (vecs[i]) begin
      do_reset();
      cyc(1, vecs[i].exp_v, 0, 0, 0, 0, "vec.push");
      cyc(0, 0, 1, vecs[i].res_v, 0, 0, "vec.pop");
      check($sformatf("vec%0d.match", i),    64'(MatchCount),    64'(vecs[i].cls == 0));
      check($sformatf("vec%0d.round", i),    64'(RoundCount),    64'(vecs[i].cls == 1));
      check($sformatf("vec%0d.mismatch", i), 64'(MismatchCount), 64'(vecs[i].cls == 2));
      check($sformatf("vec%0d.failseen", i), 64'(FailSeen),      64'(vecs[i].cls != 0));
      check($sformatf("vec%0d.level", i),    64'(Level),         64'd0);
      $display("vec %0d exp=%08h res=%08h cls=%0d", i, vecs[i].exp_v, vecs[i].res_v, vecs[i].cls);
    end

    // Second failure must not overwrite the first capture
    do_reset();
    cyc(1, 32'h3F800000, 0, 0, 0, 0, "ff.push1");
    cyc(0, 0, 1, 32'hBF800000, 0, 0, "ff.pop1");
    cyc(1, 32'h40800000, 0, 0, 0, 0, "ff.push2");
    cyc(0, 0, 1, 32'h00000000, 0, 0, "ff.pop2");
    check("ff.mismatch", 64'(MismatchCount), 64'd2);
    check("ff.idx", 64'(FirstFailIdx), 64'd0);
    check("ff.exp", 64'(FirstFailExp), 64'h3F800000);
    check("ff.res", 64'(FirstFailRes), 64'hBF800000);

    // Fill, overflow push ignored, drain, then orphan
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 32'h3F800000 + 32'(i), 0, 0, 0, 0, "fill");
    check("fill.ready", 64'(ExpReady), 64'd0);
    check("fill.level", 64'(Level), 64'd8);
    cyc(1, 32'h12345678, 1, 32'h3F800000, 0, 0, "full.pushpop");
    check("full.nobypass", 64'(Level), 64'd7);
    cyc(1, 32'h3F800008, 0, 0, 0, 0, "refill");
    for (int i = 1; i < 9; i++) cyc(0, 0, 1, 32'h3F800000 + 32'(i), 0, 0, "drain");
    check("drain.match", 64'(MatchCount), 64'd9);
    check("drain.level", 64'(Level), 64'd0);
    cyc(1, 32'h40000000, 1, 32'h40000000, 0, 0, "orphan");
    check("orphan.count", 64'(OrphanCount), 64'd1);
    check("orphan.level", 64'(Level), 64'd1);
    check("orphan.match", 64'(MatchCount), 64'd9);

    // Mid-stream reset / clear with simultaneous push and pop
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cyc(1, 32'h3F800000, 0, 0, 0, 0, "mid.a");
      cyc(0, 0, 1, 32'h3F800001, 0, 0, "mid.b");
      for (int i = 0; i < 3; i++) cyc(1, 32'h40000000, 0, 0, 0, 0, "mid.fill");
      check("mid.level3", 64'(Level), 64'd3);
      cyc(1, 32'h41000000, 1, 32'h40000000, (k == 0), (k == 1), "mid.rst");
      check("mid.level0", 64'(Level), 64'd0);
      check("mid.ready", 64'(ExpReady), 64'd1);
      check("mid.round", 64'(RoundCount), 64'd0);
      check("mid.failseen", 64'(FailSeen), 64'd0);
      cyc(0, 0, 1, 32'h41000000, 0, 0, "mid.after");
      check("mid.orphan", 64'(OrphanCount), 64'd1);
    end

    // Randomized traffic with occasional reset/clear
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ed = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      rd = $urandom;
      if (m_q.size() != 0) begin
        mode = $urandom_range(0, 9);
        case (mode)
          0, 1: rd = m_q[0];
          2:    rd = m_q[0] + 32'd1;
          3:    rd = m_q[0] - 32'd1;
          4:    rd = m_q[0] + 32'd2;
          5:    rd = m_q[0] ^ 32'h80000000;
          6:    rd = specials[$urandom_range(0, 7)];
          default: rd = $urandom;
        endcase
      end
      cyc(($urandom_range(0, 1) == 1), ed, ($urandom_range(0, 2) != 0), rd,
          ($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0), "rand");
    end
    $display("random phase done: match=%0d round=%0d mismatch=%0d orphan=%0d",
             m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
